// File: rtl/zero_unpad.sv
// Strips TRIM leading and TRIM trailing vectors from every frame, forwards the interior
// through a one-deep registered output stage and flags non-zero pad or runt frames.
module zero_unpad #(
   parameter  int BW         = 8,
   parameter  int VECTOR_LEN = 13,
   parameter  int TRIM       = 1,
   localparam int VECTOR_BW  = BW * VECTOR_LEN
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic signed [VECTOR_BW-1:0] data_i,
   input  logic                        valid_i,
   input  logic                        last_i,
   output logic                        ready_o,
   output logic signed [VECTOR_BW-1:0] data_o,
   output logic                        valid_o,
   output logic                        last_o,
   input  logic                        ready_i,
   output logic                        pad_err_o,
   output logic                        runt_o
);

   localparam int CW = $clog2(2 * TRIM + 1);
   localparam int OW = $clog2(TRIM + 1);
   localparam logic [CW-1:0] POS_TRIM = CW'(TRIM);
   localparam logic [CW-1:0] POS_SAT  = CW'(2 * TRIM);
   localparam logic [OW-1:0] OCC_FULL = OW'(TRIM);

   logic        [CW-1:0]        pos_q;
   logic        [OW-1:0]        occ_q;
   logic signed [VECTOR_BW-1:0] hold_p0 [TRIM];
   logic signed [VECTOR_BW-1:0] data_p1;
   logic                        vld_p1;
   logic                        last_p1;
   logic                        pad_p1;
   logic                        runt_p1;

   logic accept;
   logic head;
   logic full;
   logic pop;
   logic tail_err;

   assign ready_o = !vld_p1 | ready_i;
   assign accept  = valid_i & ready_o;
   assign head    = pos_q < POS_TRIM;
   assign full    = occ_q == OCC_FULL;
   assign pop     = accept & !head & full;

   // Trailing pad on a last beat: every occupied slot except the one popping out, plus the incoming word.
   always_comb begin
      tail_err = (data_i != '0);
      for (int i = 0; i < TRIM; i++) begin
         if ((OW'(i) < occ_q) && !(full && (i == 0)) && (hold_p0[i] != '0)) begin
            tail_err = 1'b1;
         end
      end
   end

   // Stage p0: hold buffer, oldest entry at index 0
   always_ff @(posedge clk_i) begin
      if (accept && !head) begin
         for (int i = 0; i < TRIM; i++) begin
            if (full) begin
               hold_p0[i] <= (i == TRIM - 1) ? data_i : hold_p0[(i + 1) % TRIM];
            end else if (OW'(i) == occ_q) begin
               hold_p0[i] <= data_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pos_q <= '0;
         occ_q <= '0;
      end else if (accept) begin
         if (last_i) begin
            pos_q <= '0;
            occ_q <= '0;
         end else begin
            if (pos_q != POS_SAT) begin
               pos_q <= pos_q + CW'(1);
            end
            if (!head && !full) begin
               occ_q <= occ_q + OW'(1);
            end
         end
      end
   end

   // Stage p1: registered output beat and status pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         pad_p1  <= 1'b0;
         runt_p1 <= 1'b0;
      end else begin
         if (pop) begin
            data_p1 <= hold_p0[0];
            vld_p1  <= 1'b1;
            last_p1 <= last_i;
         end else if (ready_i) begin
            vld_p1  <= 1'b0;
         end
         pad_p1  <= accept & (head ? (data_i != '0) : (last_i & tail_err));
         runt_p1 <= accept & last_i & (pos_q != POS_SAT);
      end
   end

   assign data_o    = data_p1;
   assign valid_o   = vld_p1;
   assign last_o    = last_p1;
   assign pad_err_o = pad_p1;
   assign runt_o    = runt_p1;

endmodule

// File: tb/tb_zero_unpad.sv
// Bench for zero_unpad: channel 0 runs TRIM=1, channel 1 runs TRIM=2, each checked
// every cycle against a frame-level model plus hand-computed tallies.
module tb_zero_unpad;

   localparam int BW  = 8;
   localparam int VL  = 13;
   localparam int VBW = BW * VL;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [VBW-1:0] din  [2];
   logic           vin  [2];
   logic           lin  [2];
   logic           rdy_o[2];
   logic [VBW-1:0] dout [2];
   logic           vout [2];
   logic           lout [2];
   logic           rdy_i[2];
   logic           pad  [2];
   logic           runt [2];

   int mode [2] = '{0, 0};
   int pend [2] = '{0, 0};
   int n_beat[2] = '{0, 0};
   int n_last[2] = '{0, 0};
   int n_pad [2] = '{0, 0};
   int n_runt[2] = '{0, 0};
   int tests = 0;
   int fails = 0;

   task automatic check_bit(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic check_vec(input string nm, input logic [VBW-1:0] act, input logic [VBW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [VBW-1:0] vec(input logic [7:0] b);
      return {VL{b}};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : ch
      localparam int T = g + 1;

      zero_unpad #(.BW(BW), .VECTOR_LEN(VL), .TRIM(T)) dut (
         .clk_i    (clk),
         .rst_i    (rst),
         .data_i   (din[g]),
         .valid_i  (vin[g]),
         .last_i   (lin[g]),
         .ready_o  (rdy_o[g]),
         .data_o   (dout[g]),
         .valid_o  (vout[g]),
         .last_o   (lout[g]),
         .ready_i  (rdy_i[g]),
         .pad_err_o(pad[g]),
         .runt_o   (runt[g])
      );

      logic [VBW-1:0] fr[$];
      logic [VBW-1:0] expd[$];
      logic           expl[$];
      logic           exp_pad, exp_runt, prev_stall, prev_last;
      logic [VBW-1:0] prev_data;

      initial begin
         rdy_i[g] = 1'b1;
         forever begin
            @(posedge clk);
            #1;
            case (mode[g])
               0:       rdy_i[g] = 1'b1;
               1:       rdy_i[g] = ~rdy_i[g];
               default: rdy_i[g] = 1'b0;
            endcase
         end
      end

      // Frame-level model: beat j of a frame of length L is output iff T <= j < L-T,
      // and it is released when beat j+T arrives.
      initial begin
         exp_pad = 1'b0; exp_runt = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
         forever begin
            @(negedge clk);
            if (rst) begin
               check_bit("reset_valid", vout[g], 1'b0);
               check_bit("reset_flags", lout[g] | pad[g] | runt[g], 1'b0);
               check_vec("reset_data", dout[g], '0);
               fr.delete(); expd.delete(); expl.delete();
               exp_pad = 1'b0; exp_runt = 1'b0; prev_stall = 1'b0;
            end else begin
               check_bit("pad_err", pad[g], exp_pad);
               check_bit("runt", runt[g], exp_runt);
               n_pad[g]  += int'(pad[g]);
               n_runt[g] += int'(runt[g]);
               if (prev_stall) begin
                  check_bit("stall_valid", vout[g], 1'b1);
                  check_vec("stall_data", dout[g], prev_data);
                  check_bit("stall_last", lout[g], prev_last);
               end
               if (vout[g] && rdy_i[g]) begin
                  n_beat[g]++;
                  n_last[g] += int'(lout[g]);
                  if (expd.size() == 0) begin
                     check_bit("spurious_beat", 1'b1, 1'b0);
                  end else begin
                     check_vec("out_data", dout[g], expd.pop_front());
                     check_bit("out_last", lout[g], expl.pop_front());
                  end
               end
               prev_stall = vout[g] & !rdy_i[g];
               prev_data  = dout[g];
               prev_last  = lout[g];
               exp_pad  = 1'b0;
               exp_runt = 1'b0;
               if (vin[g] && rdy_o[g]) begin
                  int p, len, lo;
                  p = fr.size();
                  fr.push_back(din[g]);
                  len = p + 1;
                  if (p >= 2 * T) begin
                     expd.push_back(fr[p - T]);
                     expl.push_back(lin[g]);
                  end
                  exp_pad = (p < T) && (din[g] != '0);
                  if (lin[g]) begin
                     lo = (T > len - T) ? T : len - T;
                     for (int j = lo; j < len; j++) if (fr[j] != '0) exp_pad = 1'b1;
                     exp_runt = (len <= 2 * T);
                     fr.delete();
                  end
               end
            end
            pend[g] = expd.size();
         end
      end
   end

   task automatic beat(input int c, input logic [VBW-1:0] d, input logic l);
      int  n;
      logic acc;
      n = 0;
      din[c] = d; vin[c] = 1'b1; lin[c] = l;
      do begin
         @(negedge clk);
         acc = rdy_o[c];
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) check_bit("accept_timeout", 1'b0, 1'b1);
      din[c] = '0; vin[c] = 1'b0; lin[c] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [VBW-1:0] va, vb, vc, vd, vx, top;

   initial begin
      va = vec(8'h11); vb = vec(8'h22); vc = vec(8'hC3); vd = vec(8'h4D); vx = vec(8'h9A);
      top = '0; top[VBW-1] = 1'b1;
      for (int c = 0; c < 2; c++) begin
         din[c] = '0; vin[c] = 1'b0; lin[c] = 1'b0;
      end
      idle(3);
      rst = 1'b0;
      idle(2);

      // [0,A,B,C,0]: C appears the cycle after the last input beat
      beat(0, '0, 0); beat(0, va, 0); beat(0, vb, 0); beat(0, vc, 0); beat(0, '0, 1);
      check_bit("s1_valid", vout[0], 1'b1);
      check_vec("s1_data", dout[0], vc);
      check_bit("s1_last", lout[0], 1'b1);
      idle(3);
      check_int("s1_beats", n_beat[0], 3);
      check_int("s1_lasts", n_last[0], 1);
      check_int("s1_pads", n_pad[0], 0);

      // [5,A,B,7]: two pad errors
      beat(0, VBW'(5), 0); beat(0, va, 0); beat(0, vb, 0); beat(0, VBW'(7), 1);
      idle(3);
      check_int("s2_beats", n_beat[0], 5);
      check_int("s2_pads", n_pad[0], 2);

      // trailing pad with only the top bit set
      beat(0, '0, 0); beat(0, va, 0); beat(0, top, 1);
      idle(3);
      check_int("s2b_pads", n_pad[0], 3);

      // runts: [0,0] and [7] (pad and runt together)
      beat(0, '0, 0); beat(0, '0, 1);
      beat(0, VBW'(7), 1);
      idle(3);
      check_int("runt_cnt", n_runt[0], 2);
      check_int("runt_pads", n_pad[0], 4);

      // TRIM=2: [0,0,0,0] runt, then [0,0,X,0,0] -> X last
      beat(1, '0, 0); beat(1, '0, 0); beat(1, '0, 0); beat(1, '0, 1);
      beat(1, '0, 0); beat(1, '0, 0); beat(1, vx, 0); beat(1, '0, 0); beat(1, '0, 1);
      check_vec("t2_data", dout[1], vx);
      check_bit("t2_last", lout[1], 1'b1);
      idle(3);
      check_int("t2_runts", n_runt[1], 1);
      check_int("t2_beats", n_beat[1], 1);

      // back-to-back frames with toggling ready
      mode[0] = 1;
      beat(0, '0, 0); beat(0, va, 0); beat(0, '0, 1);
      beat(0, '0, 0); beat(0, vb, 0); beat(0, '0, 1);
      idle(4);
      mode[0] = 0;
      idle(2);
      check_int("b2b_beats", n_beat[0], 8);
      check_int("b2b_lasts", n_last[0], 5);

      // downstream stall holds input off
      mode[0] = 2;
      beat(0, '0, 0); beat(0, va, 0); beat(0, vb, 0);
      din[0] = vc; vin[0] = 1'b1;
      idle(3);
      check_bit("stall_ready_o", rdy_o[0], 1'b0);
      check_bit("stall_valid_o", vout[0], 1'b1);
      check_vec("stall_data_o", dout[0], va);
      mode[0] = 0;
      beat(0, vc, 0); beat(0, '0, 1);
      idle(3);
      check_int("stall_beats", n_beat[0], 11);

      // long frame: counter saturates, 20 interior beats
      beat(0, '0, 0);
      for (int i = 0; i < 20; i++) beat(0, vec(8'(i + 1)), 0);
      beat(0, '0, 1);
      idle(3);
      check_int("long_beats", n_beat[0], 31);
      check_int("long_lasts", n_last[0], 7);

      // asynchronous reset mid-frame
      mode[0] = 2;
      beat(0, '0, 0); beat(0, va, 0); beat(0, vb, 0);
      check_bit("pre_rst_valid", vout[0], 1'b1);
      #2 rst = 1'b1;
      #1 check_bit("async_rst_valid", vout[0], 1'b0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      mode[0] = 0;
      beat(0, '0, 0); beat(0, vd, 0); beat(0, '0, 1);
      check_vec("post_rst_data", dout[0], vd);
      check_bit("post_rst_last", lout[0], 1'b1);
      idle(3);
      check_int("post_rst_beats", n_beat[0], 32);
      check_int("pending0", pend[0], 0);
      check_int("pending1", pend[1], 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
